uart_tx_buffer: RTL and testbench

- Output-direction counterpart of the core's UART input path.
- The write-back stage writes a byte; this block queues it in a FIFO and serializes it onto the TX line as 8N1, LSB first.
- Gives the core a ready/accept handshake so output instructions can stall instead of losing data.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/uart_tx_buffer.sv | 144 ++++++++++++++
 tb/tb_uart_tx_buffer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: frame constants and transmit FSM states.
// Imported by the transmit buffer and reusable by the receive side.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int DEF_CLK_PER_BIT = 868;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Count-based synchronous FIFO with registered count and comb read port.
// Pushes while full and pops while empty are dropped internally.
module sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH_LOG = 4
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH_LOG:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG + 1)'(DEPTH);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG-1:0] r_wr_ptr;
  logic [DEPTH_LOG-1:0] r_rd_ptr;
  logic [DEPTH_LOG:0]   r_count;
  logic                 w_push;
  logic                 w_pop;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage array; contents need no reset since count guards reads.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally; count tracks occupancy.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered 8N1 UART transmitter fed by the write-back stage.
// FIFO absorbs bursts; output_ready lets the core stall instead of dropping.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT    = DEF_CLK_PER_BIT,
  parameter int FIFO_DEPTH_LOG = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic        output_ready,
  output logic        overflow,
  output logic        busy,
  output logic        txd
);

  localparam int BW = $clog2(CLK_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

  tx_state_t                r_state;
  tx_state_t                w_state_nxt;
  logic [BW-1:0]            r_baud;
  logic [BW-1:0]            w_baud_nxt;
  logic [2:0]               r_bit;
  logic [2:0]               w_bit_nxt;
  logic [7:0]               r_shift;
  logic [7:0]               w_shift_nxt;
  logic                     r_txd;
  logic                     r_overflow;
  logic                     r_busy;
  logic                     w_txd_nxt;
  logic                     w_baud_done;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic [7:0]               w_dout;
  logic [FIFO_DEPTH_LOG:0]  w_count;
  logic                     w_unused_hi;

  assign w_unused_hi  = ^write_data[31:8];
  assign output_ready = !w_full;
  assign overflow     = r_overflow;
  assign busy         = r_busy;
  assign txd          = r_txd;
  assign w_baud_done  = (r_baud == BAUD_LAST);

  sync_fifo #(
    .WIDTH     (UART_DATA_BITS),
    .DEPTH_LOG (FIFO_DEPTH_LOG)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (write_enable),
    .pop   (w_pop),
    .din   (write_data[7:0]),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // FSM, baud counter, bit index and shift register state.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state: each non-idle state lasts one bit period.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_dout;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == BIT_LAST) w_state_nxt = STOP;
          else                   w_bit_nxt   = r_bit + 1'b1;
        end
      end
      STOP: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Line level for the current state, registered one cycle later.
  always_comb begin
    w_txd_nxt = 1'b1;
    unique case (r_state)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = r_shift[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  // Registered outputs: line, sticky overflow, activity flag.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_txd      <= 1'b1;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_txd      <= w_txd_nxt;
      r_overflow <= r_overflow | (write_enable & w_full);
      r_busy     <= (r_state != IDLE) || (w_count != '0);
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with CLK_PER_BIT=4, depth 4.
// A line monitor decodes frames; the main block checks timing and data.
module tb_uart_tx_buffer;

  localparam int CPB = 4;
  localparam int GAP = 10 * CPB + 1;

  logic        CLK;
  logic        reset;
  logic        write_enable;
  logic [31:0] write_data;
  logic        output_ready;
  logic        overflow;
  logic        busy;
  logic        txd;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mon_err  = 0;

  logic [7:0] rx_q  [$];
  int         rx_t  [$];
  logic [7:0] exp_q [$];

  uart_tx_buffer #(
    .CLK_PER_BIT    (CPB),
    .FIFO_DEPTH_LOG (2)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .write_enable (write_enable),
    .write_data   (write_data),
    .output_ready (output_ready),
    .overflow     (overflow),
    .busy         (busy),
    .txd          (txd)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Line monitor: mid-bit sampling on negative edges.
  always begin : mon
    int         t0;
    logic [7:0] b;
    @(negedge CLK);
    if (txd === 1'b0) begin
      t0 = cyc;
      repeat (CPB / 2) @(negedge CLK);
      if (txd !== 1'b0) mon_err++;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge CLK);
        b[i] = txd;
      end
      repeat (CPB) @(negedge CLK);
      if (txd !== 1'b1) mon_err++;
      rx_q.push_back(b);
      rx_t.push_back(t0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] d);
    write_enable = 1'b1;
    write_data   = d;
    adv(1);
    write_enable = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < maxc) begin
      adv(1);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
  endtask

  initial begin : main
    logic [9:0]  fr;
    logic [7:0]  burst [5];
    int          lows;
    int          sent;
    int          n;
    int          bad;

    reset        = 1'b1;
    write_enable = 1'b0;
    write_data   = '0;
    adv(2);
    reset = 1'b0;

    chk("rst_txd",   txd,          1);
    chk("rst_busy",  busy,         0);
    chk("rst_ready", output_ready, 1);
    chk("rst_ovf",   overflow,     0);

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      adv(1);
      if (txd !== 1'b1 || busy !== 1'b0 ||
          output_ready !== 1'b1 || overflow !== 1'b0) bad++;
    end
    chk("idle50_bad_cycles", bad, 0);

    // Single 0xA5 frame, cycle-exact.
    wr(32'h0000_00A5);
    chk("a5_ready", output_ready, 1);
    adv(1);
    chk("a5_txd_n1",  txd,  1);
    chk("a5_busy_n1", busy, 1);
    adv(1);
    chk("a5_fall_n2", txd, 0);
    fr = {1'b1, 8'hA5, 1'b0};
    adv(2);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("a5_bit%0d", k), txd, fr[k]);
      if (k < 9) adv(CPB);
    end
    adv(1);
    chk("a5_busy_n41", busy, 1);
    chk("a5_stop_n41", txd,  1);
    adv(1);
    chk("a5_busy_n42", busy, 0);
    chk("a5_txd_n42",  txd,  1);
    adv(2);
    chk("a5_rx_n", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("a5_rx_byte", rx_q[0], 8'hA5);
    clear_rx();

    // Burst into a busy transmitter: four fit, fifth overflows.
    burst[0] = 8'h11;
    burst[1] = 8'h22;
    burst[2] = 8'h33;
    burst[3] = 8'h44;
    burst[4] = 8'h55;
    wr(32'h0000_005A);
    adv(1);
    write_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      write_data = {24'h0, burst[i]};
      adv(1);
      if (i == 2) chk("burst_ready3", output_ready, 1);
      if (i == 3) begin
        chk("burst_ready4", output_ready, 0);
        chk("burst_ovf4",   overflow,     0);
      end
      if (i == 4) begin
        chk("burst_ready5", output_ready, 0);
        chk("burst_ovf5",   overflow,     1);
      end
    end
    write_enable = 1'b0;
    adv(4);
    wait_idle(600, "burst_idle_timeout");
    adv(3);
    exp_q = '{8'h5A, 8'h11, 8'h22, 8'h33, 8'h44};
    chk("burst_rx_n", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("burst_byte%0d", i),
          (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD, exp_q[i]);
      if (i > 0)
        chk($sformatf("burst_gap%0d", i),
            (i < rx_t.size()) ? rx_t[i] - rx_t[i-1] : -1, GAP);
    end
    chk("burst_ovf_sticky", overflow, 1);
    clear_rx();

    // Push in the same cycle IDLE pops the only byte.
    write_enable = 1'b1;
    write_data   = 32'h0000_003C;
    adv(1);
    write_data   = 32'hFFFF_FFC3;
    adv(1);
    write_enable = 1'b0;
    chk("pp_ready", output_ready, 1);
    chk("pp_busy",  busy,         1);
    adv(4);
    wait_idle(300, "pp_idle_timeout");
    adv(3);
    chk("pp_rx_n", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("pp_byte0", rx_q[0], 8'h3C);
      chk("pp_byte1", rx_q[1], 8'hC3);
      chk("pp_gap",   rx_t[1] - rx_t[0], GAP);
    end
    clear_rx();

    // Reset during DATA bit 3 of 0xFF with a second byte queued.
    chk("rst_pre_ovf", overflow, 1);
    write_enable = 1'b1;
    write_data   = 32'h0000_00FF;
    adv(1);
    write_data   = 32'h0000_0081;
    adv(1);
    write_enable = 1'b0;
    adv(17);
    reset = 1'b1;
    adv(1);
    reset = 1'b0;
    chk("midrst_txd",   txd,          1);
    chk("midrst_busy",  busy,         0);
    chk("midrst_ready", output_ready, 1);
    chk("midrst_ovf",   overflow,     0);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      adv(1);
      if (txd !== 1'b1) lows++;
    end
    chk("midrst_no_frames", lows, 0);
    chk("midrst_busy_end",  busy, 0);
    clear_rx();

    // Random bytes written only when output_ready is high.
    exp_q.delete();
    sent = 0;
    n    = 0;
    while (sent < 200 && n < 30000) begin
      if (output_ready === 1'b1 && $urandom_range(0, 2) == 0) begin
        write_enable = 1'b1;
        write_data   = $urandom;
        exp_q.push_back(write_data[7:0]);
        sent++;
      end else begin
        write_enable = 1'b0;
      end
      adv(1);
      n++;
    end
    write_enable = 1'b0;
    chk("rand_sent", sent, 200);
    adv(2);
    wait_idle(20000, "rand_idle_timeout");
    adv(3);
    chk("rand_rx_n", rx_q.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
    chk("rand_byte_mismatches", bad, 0);
    chk("rand_ovf", overflow, 0);
    chk("mon_frame_errors", mon_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
